// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined IEEE-754 multiplier, RNE, valid/ready.
// Ports: clk, rst_n (sync low), in_valid/in_ready/A/B, out_valid/out_ready/result,
// out_flags {NV,OF,UF,NX} only when FMUL_FLAGS_EN is defined.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int XLEN = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
`ifdef FMUL_FLAGS_EN
  ,
  output logic [3:0]      out_flags
`endif
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int PW   = 2*MAN_W + 2;

  typedef logic signed [EXP_W+1:0] exp_t;

  localparam exp_t EMAX = exp_t'(2**EXP_W - 1);

  localparam logic [XLEN-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack / classify / multiply
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;

  // subnormal inputs collapse to zero
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (&ea) & (fa == '0);
  assign ib = (&eb) & (fb == '0);
  assign na = (&ea) & (fa != '0);
  assign nb = (&eb) & (fb != '0);

  logic            sgn_d;
  logic            sp_d;
  logic [XLEN-1:0] spv_d;
  exp_t            e_d;
  logic [PW-1:0]   p_d;

  always_comb begin
    sgn_d = sa ^ sb;
    sp_d  = 1'b1;
    spv_d = {sgn_d, {(XLEN-1){1'b0}}};
    if (na | nb)
      spv_d = QNAN;
    else if ((ia & zb) | (za & ib))
      spv_d = QNAN;
    else if (ia | ib)
      spv_d = {sgn_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (za | zb)
      spv_d = {sgn_d, {(XLEN-1){1'b0}}};
    else
      sp_d = 1'b0;
  end

  assign e_d = exp_t'({2'b00, ea}) + exp_t'({2'b00, eb})
             - exp_t'(BIAS);
  assign p_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

  logic            v1, s1, sp1;
  logic [XLEN-1:0] spv1;
  exp_t            e1;
  logic [PW-1:0]   p1;

  // ---------------- S2: normalise, guard / sticky
  logic             msb;
  exp_t             e2_d;
  logic [MAN_W-1:0] m2_d;
  logic             g2_d, st2_d;

  assign msb  = p1[PW-1];
  assign e2_d = e1 + exp_t'(msb);

  always_comb begin
    if (msb) begin
      m2_d  = p1[PW-2:MAN_W+1];
      g2_d  = p1[MAN_W];
      st2_d = |p1[MAN_W-1:0];
    end else begin
      m2_d  = p1[PW-3:MAN_W];
      g2_d  = p1[MAN_W-1];
      st2_d = |p1[MAN_W-2:0];
    end
  end

  logic             v2, s2, sp2, g2, st2;
  logic [XLEN-1:0]  spv2;
  exp_t             e2;
  logic [MAN_W-1:0] m2;

  // ---------------- S3: round, range check, pack
  logic             rup, cy, ovf, unf;
  exp_t             e3;
  logic [MAN_W-1:0] f3;
  logic [XLEN-1:0]  res_d;

  assign rup = g2 & (st2 | m2[0]);
  // all-ones fraction plus round-up carries into the exponent
  assign cy  = rup & (&m2);
  assign f3  = m2 + MAN_W'(rup);
  assign e3  = e2 + exp_t'(cy);
  assign ovf = (e3 >= EMAX);
  assign unf = (e3 <= exp_t'(0));

  always_comb begin
    if (sp2)
      res_d = spv2;
    else if (ovf)
      res_d = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)
      res_d = {s2, {(XLEN-1){1'b0}}};
    else
      res_d = {s2, e3[EXP_W-1:0], f3};
  end

`ifdef FMUL_FLAGS_EN
  logic       nv_d, nv1, nv2;
  logic [3:0] flags_d;

  assign nv_d = ~(na | nb) & ((ia & zb) | (za & ib));

  always_comb begin
    if (sp2)
      flags_d = {nv2, 3'b000};
    else
      flags_d = {1'b0, ovf, unf, ovf | unf | g2 | st2};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nv1       <= 1'b0;
      nv2       <= 1'b0;
      out_flags <= '0;
    end else if (adv) begin
      nv1       <= nv_d;
      nv2       <= nv1;
      out_flags <= flags_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1        <= 1'b0;
      sp1       <= 1'b0;
      spv1      <= '0;
      e1        <= '0;
      p1        <= '0;
      v2        <= 1'b0;
      s2        <= 1'b0;
      sp2       <= 1'b0;
      spv2      <= '0;
      e2        <= '0;
      m2        <= '0;
      g2        <= 1'b0;
      st2       <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      s1        <= sgn_d;
      sp1       <= sp_d;
      spv1      <= spv_d;
      e1        <= e_d;
      p1        <= p_d;
      v2        <= v1;
      s2        <= s1;
      sp2       <= sp1;
      spv2      <= spv1;
      e2        <= e2_d;
      m2        <= m2_d;
      g2        <= g2_d;
      st2       <= st2_d;
      out_valid <= v2;
      result    <= res_d;
    end
  end

endmodule
